// File: rtl/internal_regs_package.sv
// Shared pipeline-register types and write-back/commit definitions.
// Imported by the write-back commit stage and its data mux.
package internal_regs_package;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_CSR = 2'b11;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} commit_state_e;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [1:0]      priv;
  } trap_info_t;

  typedef struct packed {
    logic            valid;
    logic            Reg_Write;
    logic [4:0]      rd_addr;
    logic [1:0]      WBSel;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] data_from_mem;
    logic [XLEN-1:0] PC_4;
    logic [XLEN-1:0] csr_rdata;
    logic            is_csr_inst;
    logic            csr_wen;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            exception_valid;
    logic [XLEN-1:0] exception_cause;
    logic [XLEN-1:0] inst_pc;
    logic [1:0]      inst_priv_level;
    logic            is_ecall_inst;
    logic            is_mret_inst;
  } mem_wb_reg_t;

  // Vectored mode only applies to interrupts (cause MSB set); offset is 4*cause.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && cause[XLEN-1])
      return base + {cause[XLEN-3:0], 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/wb_data_mux.sv
// Write-back data selection: ALU result, load data, PC+4 or CSR read value.
module wb_data_mux
  import internal_regs_package::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] data_from_mem,
  input  logic [W-1:0] pc_4,
  input  logic [W-1:0] csr_rdata,
  output logic [W-1:0] wdata
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves wdata unassigned (no latch).
    wdata = alu_result;
    unique case (sel)
      WB_ALU:  wdata = alu_result;
      WB_MEM:  wdata = data_from_mem;
      WB_PC4:  wdata = pc_4;
      WB_CSR:  wdata = csr_rdata;
      default: wdata = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Final pipeline stage: register-file/CSR write-back, trap and mret commit with
// registered redirect followed by a fixed-length flush/drain, and instret counting.
module wb_commit_unit
  import internal_regs_package::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DRAIN_CYCLES  = 3,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  mem_wb_reg_t              mem_wb_i,
  input  logic                     wb_stall_i,
  input  logic [DATA_WIDTH-1:0]    mtvec_i,
  input  logic [DATA_WIDTH-1:0]    mepc_i,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [DATA_WIDTH-1:0]    rf_wdata_o,
  output logic                     csr_we_o,
  output logic [11:0]              csr_waddr_o,
  output logic [DATA_WIDTH-1:0]    csr_wdata_o,
  output logic                     trap_take_o,
  output logic [DATA_WIDTH-1:0]    trap_cause_o,
  output logic [DATA_WIDTH-1:0]    trap_epc_o,
  output logic [1:0]               trap_priv_o,
  output logic                     mret_o,
  output logic                     redirect_valid_o,
  output logic [DATA_WIDTH-1:0]    redirect_pc_o,
  output logic                     flush_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  commit_state_e state;
  logic [3:0]    drain_cnt;
  trap_info_t    trap_info_q;

  logic accept, commit, trap_hit, mret_hit;
  logic unused_ecall;

  // Entries are only acted on in RUN; anything arriving during FLUSH/DRAIN is squashed.
  assign accept   = mem_wb_i.valid && !wb_stall_i && (state == RUN);
  assign commit   = accept && !mem_wb_i.exception_valid;
  assign trap_hit = accept && mem_wb_i.exception_valid;
  assign mret_hit = commit && mem_wb_i.is_mret_inst;

  // ecall is already folded into exception_valid upstream.
  assign unused_ecall = mem_wb_i.is_ecall_inst;

  assign rf_we_o     = commit && mem_wb_i.Reg_Write && (mem_wb_i.rd_addr != 5'd0);
  assign rf_waddr_o  = mem_wb_i.rd_addr;
  assign csr_we_o    = commit && mem_wb_i.is_csr_inst && mem_wb_i.csr_wen;
  assign csr_waddr_o = mem_wb_i.csr_addr;
  assign csr_wdata_o = mem_wb_i.csr_wdata;

  wb_data_mux #(.W(DATA_WIDTH)) u_wb_data_mux (
    .sel           (mem_wb_i.WBSel),
    .alu_result    (mem_wb_i.alu_result),
    .data_from_mem (mem_wb_i.data_from_mem),
    .pc_4          (mem_wb_i.PC_4),
    .csr_rdata     (mem_wb_i.csr_rdata),
    .wdata         (rf_wdata_o)
  );

  assign trap_cause_o = trap_info_q.cause;
  assign trap_epc_o   = trap_info_q.epc;
  assign trap_priv_o  = trap_info_q.priv;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      drain_cnt        <= '0;
      trap_info_q      <= '0;
      trap_take_o      <= 1'b0;
      mret_o           <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      flush_o          <= 1'b0;
      instret_o        <= '0;
    end else begin
      trap_take_o      <= 1'b0;
      mret_o           <= 1'b0;
      redirect_valid_o <= 1'b0;

      if (commit)
        instret_o <= instret_o + INSTRET_WIDTH'(1);

      unique case (state)
        RUN: begin
          if (trap_hit) begin
            state            <= FLUSH;
            trap_take_o      <= 1'b1;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= trap_target(mtvec_i, mem_wb_i.exception_cause);
            trap_info_q      <= '{cause: mem_wb_i.exception_cause,
                                  epc:   mem_wb_i.inst_pc,
                                  priv:  mem_wb_i.inst_priv_level};
            flush_o          <= 1'b1;
          end else if (mret_hit) begin
            state            <= FLUSH;
            mret_o           <= 1'b1;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= mepc_i;
            flush_o          <= 1'b1;
          end
        end
        FLUSH: begin
          state     <= DRAIN;
          drain_cnt <= 4'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state   <= RUN;
            flush_o <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: begin
          state   <= RUN;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: vector table for write-back, scoreboard
// queue for redirects, hand sequences for trap/mret/drain/reset/wrap corners.
module tb_wb_commit_unit;
  import internal_regs_package::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  mem_wb_reg_t mem_wb_i, mem_wb_b;
  logic        wb_stall_i, stall_b;
  logic [31:0] mtvec_i, mepc_i;

  logic        rf_we_o, csr_we_o, trap_take_o, mret_o, redirect_valid_o, flush_o;
  logic [4:0]  rf_waddr_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] rf_wdata_o, csr_wdata_o, trap_cause_o, trap_epc_o, redirect_pc_o;
  logic [1:0]  trap_priv_o;
  logic [63:0] instret_o;

  logic        rf_we_b, csr_we_b, trap_take_b, mret_b, redirect_valid_b, flush_b;
  logic [4:0]  rf_waddr_b;
  logic [11:0] csr_waddr_b;
  logic [31:0] rf_wdata_b, csr_wdata_b, trap_cause_b, trap_epc_b, redirect_pc_b;
  logic [1:0]  trap_priv_b;
  logic [3:0]  instret_b;

  always #5 clk = ~clk;

  wb_commit_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_wb_i(mem_wb_i), .wb_stall_i(wb_stall_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .trap_take_o(trap_take_o), .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o),
    .trap_priv_o(trap_priv_o), .mret_o(mret_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .instret_o(instret_o)
  );

  // Short drain and narrow counter: exercises DRAIN_CYCLES=1 and instret wrap.
  wb_commit_unit #(.DRAIN_CYCLES(1), .INSTRET_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_wb_i(mem_wb_b), .wb_stall_i(stall_b),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .rf_we_o(rf_we_b), .rf_waddr_o(rf_waddr_b), .rf_wdata_o(rf_wdata_b),
    .csr_we_o(csr_we_b), .csr_waddr_o(csr_waddr_b), .csr_wdata_o(csr_wdata_b),
    .trap_take_o(trap_take_b), .trap_cause_o(trap_cause_b), .trap_epc_o(trap_epc_b),
    .trap_priv_o(trap_priv_b), .mret_o(mret_b), .redirect_valid_o(redirect_valid_b),
    .redirect_pc_o(redirect_pc_b), .flush_o(flush_b), .instret_o(instret_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [1:0]  priv;
    logic        is_trap;
  } redir_t;

  redir_t exp_q[$];
  redir_t got_e;

  // Scoreboard: every redirect pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && redirect_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_redirect", 64'd1, 64'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("redirect_pc", redirect_pc_o, got_e.pc);
        check("trap_take", trap_take_o, got_e.is_trap);
        check("mret_pulse", mret_o, !got_e.is_trap);
        if (got_e.is_trap) begin
          check("trap_cause", trap_cause_o, got_e.cause);
          check("trap_epc", trap_epc_o, got_e.epc);
          check("trap_priv", trap_priv_o, got_e.priv);
        end
      end
    end
    if (rst_n && (trap_take_o || mret_o) && !redirect_valid_o)
      check("stray_pulse", 64'd1, 64'd0);
  end

  function automatic mem_wb_reg_t blank();
    mem_wb_reg_t e = '0;
    return e;
  endfunction

  function automatic mem_wb_reg_t alu_wr(input logic [4:0] rd, input logic [31:0] v);
    mem_wb_reg_t e = '0;
    e.valid      = 1'b1;
    e.Reg_Write  = 1'b1;
    e.rd_addr    = rd;
    e.WBSel      = WB_ALU;
    e.alu_result = v;
    return e;
  endfunction

  function automatic mem_wb_reg_t trap_entry(input logic [31:0] cause, input logic [31:0] pc,
                                             input logic [1:0] priv);
    mem_wb_reg_t e = alu_wr(5'd3, 32'hBAD0);
    e.is_csr_inst     = 1'b1;
    e.csr_wen         = 1'b1;
    e.exception_valid = 1'b1;
    e.exception_cause = cause;
    e.inst_pc         = pc;
    e.inst_priv_level = priv;
    return e;
  endfunction

  typedef struct {
    logic        valid;
    logic        stall;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        is_csr;
    logic        csr_wen;
    logic        exp_rf_we;
    logic [31:0] exp_wdata;
    logic        exp_csr_we;
    logic        exp_count;
  } vec_t;

  vec_t        vecs[8];
  mem_wb_reg_t e;
  logic [63:0] exp_instret = '0;
  int          flush_cnt;

  task automatic wait_drain();
    bit done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      mem_wb_i = blank();
      if (k > 0 && !flush_o) done = 1'b1;
    end
    check("drain_done", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mem_wb_i = blank(); mem_wb_b = blank();
    wb_stall_i = 1'b0; stall_b = 1'b0;
    mtvec_i = '0; mepc_i = '0;

    vecs[0] = '{1, 0, 1, 5'd5,  WB_ALU, 0, 0, 1, 32'h0000_1234, 0, 1};
    vecs[1] = '{1, 0, 1, 5'd0,  WB_ALU, 0, 0, 0, 32'h0000_1234, 0, 1};
    vecs[2] = '{1, 0, 1, 5'd7,  WB_MEM, 0, 0, 1, 32'hDEAD_BEEF, 0, 1};
    vecs[3] = '{1, 0, 1, 5'd31, WB_PC4, 0, 0, 1, 32'h0000_0104, 0, 1};
    vecs[4] = '{1, 0, 1, 5'd9,  WB_CSR, 1, 1, 1, 32'h0000_0A5A, 1, 1};
    vecs[5] = '{1, 0, 0, 5'd9,  WB_CSR, 1, 0, 0, 32'h0000_0A5A, 0, 1};
    vecs[6] = '{0, 0, 1, 5'd5,  WB_ALU, 1, 1, 0, 32'h0000_1234, 0, 0};
    vecs[7] = '{1, 1, 1, 5'd5,  WB_MEM, 1, 1, 0, 32'hDEAD_BEEF, 0, 0};

    #2;
    check("rst_flush", flush_o, 1'b0);
    check("rst_redirect_valid", redirect_valid_o, 1'b0);
    check("rst_redirect_pc", redirect_pc_o, 32'h0);
    check("rst_trap_take", trap_take_o, 1'b0);
    check("rst_instret", instret_o, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_instret_before", i), instret_o, exp_instret);
      e = blank();
      e.valid         = vecs[i].valid;
      e.Reg_Write     = vecs[i].reg_write;
      e.rd_addr       = vecs[i].rd;
      e.WBSel         = vecs[i].sel;
      e.alu_result    = 32'h0000_1234;
      e.data_from_mem = 32'hDEAD_BEEF;
      e.PC_4          = 32'h0000_0104;
      e.csr_rdata     = 32'h0000_0A5A;
      e.is_csr_inst   = vecs[i].is_csr;
      e.csr_wen       = vecs[i].csr_wen;
      e.csr_addr      = 12'h305;
      e.csr_wdata     = 32'h0000_0100;
      mem_wb_i   = e;
      wb_stall_i = vecs[i].stall;
      #1;
      check($sformatf("vec%0d_rf_we", i), rf_we_o, vecs[i].exp_rf_we);
      check($sformatf("vec%0d_rf_wdata", i), rf_wdata_o, vecs[i].exp_wdata);
      check($sformatf("vec%0d_csr_we", i), csr_we_o, vecs[i].exp_csr_we);
      if (vecs[i].exp_rf_we)
        check($sformatf("vec%0d_rf_waddr", i), rf_waddr_o, vecs[i].rd);
      if (vecs[i].exp_csr_we) begin
        check($sformatf("vec%0d_csr_waddr", i), csr_waddr_o, 12'h305);
        check($sformatf("vec%0d_csr_wdata", i), csr_wdata_o, 32'h100);
      end
      if (vecs[i].exp_count) exp_instret++;
    end
    @(negedge clk);
    mem_wb_i = blank(); wb_stall_i = 1'b0;
    check("vec_instret_after", instret_o, exp_instret);

    // Direct trap; younger valid entries during the flush window must be squashed.
    @(negedge clk);
    mtvec_i  = 32'h100;
    mem_wb_i = trap_entry(32'd2, 32'h80, 2'b11);
    #1;
    check("trap_rf_we", rf_we_o, 1'b0);
    check("trap_csr_we", csr_we_o, 1'b0);
    exp_q.push_back('{32'h100, 32'd2, 32'h80, 2'b11, 1'b1});
    flush_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) mtvec_i = 32'h300;
      if (flush_o) begin
        flush_cnt++;
        mem_wb_i = (k == 1) ? trap_entry(32'd5, 32'h84, 2'b11) : alu_wr(5'd6, 32'h55);
        #1;
        check("squash_rf_we", rf_we_o, 1'b0);
      end else begin
        mem_wb_i = blank();
      end
    end
    check("flush_cycles", flush_cnt, 4);
    check("trap_instret", instret_o, exp_instret);

    // Vectored interrupt.
    @(negedge clk);
    mtvec_i  = 32'h201;
    mem_wb_i = trap_entry(32'h8000_0007, 32'h200, 2'b00);
    exp_q.push_back('{32'h21C, 32'h8000_0007, 32'h200, 2'b00, 1'b1});
    wait_drain();

    // mret held by stall for two cycles.
    @(negedge clk);
    mepc_i = 32'h44;
    e = blank(); e.valid = 1'b1; e.is_mret_inst = 1'b1;
    mem_wb_i = e; wb_stall_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mret_stalled_redirect", redirect_valid_o, 1'b0);
      check("mret_stalled_flush", flush_o, 1'b0);
      check("mret_stalled_instret", instret_o, exp_instret);
    end
    wb_stall_i = 1'b0;
    exp_q.push_back('{32'h44, 32'h0, 32'h0, 2'b00, 1'b0});
    exp_instret++;
    wait_drain();
    check("mret_instret", instret_o, exp_instret);

    // Exception and mret on one entry: trap wins, nothing retired.
    @(negedge clk);
    mtvec_i  = 32'h100;
    e = trap_entry(32'd3, 32'h90, 2'b11); e.is_mret_inst = 1'b1;
    mem_wb_i = e;
    exp_q.push_back('{32'h100, 32'd3, 32'h90, 2'b11, 1'b1});
    wait_drain();
    check("trap_mret_instret", instret_o, exp_instret);

    // Reset while draining.
    @(negedge clk);
    mem_wb_i = trap_entry(32'd2, 32'hA0, 2'b01);
    exp_q.push_back('{32'h100, 32'd2, 32'hA0, 2'b01, 1'b1});
    @(negedge clk); mem_wb_i = blank();
    @(negedge clk);
    check("pre_reset_flush", flush_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_drain_flush", flush_o, 1'b0);
    check("reset_drain_redirect", redirect_valid_o, 1'b0);
    check("reset_drain_instret", instret_o, 64'h0);
    exp_instret = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_flush", flush_o, 1'b0);
    mem_wb_i = alu_wr(5'd4, 32'h77);
    #1;
    check("post_reset_rf_we", rf_we_o, 1'b1);
    exp_instret++;
    @(negedge clk); mem_wb_i = blank();
    check("post_reset_instret", instret_o, exp_instret);

    // Narrow counter wrap and single-cycle drain on the second instance.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) check("instret_b_max", instret_b, 4'hF);
      mem_wb_b = alu_wr(5'd1, 32'(i));
    end
    @(negedge clk);
    mem_wb_b = blank();
    check("instret_b_wrap", instret_b, 4'h0);
    mtvec_i  = 32'h400;
    mem_wb_b = trap_entry(32'd11, 32'hC0, 2'b11);
    flush_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("b_trap_take", trap_take_b, 1'b1);
        check("b_redirect_pc", redirect_pc_b, 32'h400);
      end
      mem_wb_b = flush_b ? alu_wr(5'd2, 32'h9) : blank();
      if (flush_b) flush_cnt++;
    end
    check("b_flush_cycles", flush_cnt, 2);
    check("b_instret_after_trap", instret_b, 4'h0);

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
